// File: rtl/mem_resp_pkg.sv
// Shared types for the memory responder: access size encoding, FSM states, request record.
// Pure declarations; no timing or flow control of its own.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic        write;
    size_e       size;
    logic        is_unsigned;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  // Right-aligned bit mask covering the bytes of one access of the given size.
  function automatic logic [63:0] size_mask(input size_e s);
    case (s)
      SZ_B:    return 64'h0000_0000_0000_00FF;
      SZ_H:    return 64'h0000_0000_0000_FFFF;
      SZ_W:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for one 64-bit doubleword: load extract+extend, store merge, alignment check.
// Purely combinational, zero latency; no handshake.
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [2:0]  offset,
  input  logic [63:0] wdata,
  input  logic [63:0] rd_dword,
  output logic        misaligned,
  output logic [63:0] load_data,
  output logic [63:0] merged
);

  logic [5:0]  sh;
  logic [63:0] shifted;
  logic [63:0] lane_mask;

  always_comb begin
    sh         = {offset, 3'b000};
    shifted    = rd_dword >> sh;
    lane_mask  = size_mask(size) << sh;
    merged     = (rd_dword & ~lane_mask) | ((wdata << sh) & lane_mask);
    misaligned = 1'b0;
    load_data  = shifted;
    case (size)
      SZ_B: begin
        load_data = is_unsigned ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        misaligned = offset[0];
        load_data  = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        misaligned = |offset[1:0];
        load_data  = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      end
      SZ_D: begin
        // Doubleword loads fill the whole result, so signedness has no effect.
        misaligned = |offset;
        load_data  = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-port doubleword memory answering one load/store at a time after WAIT_CYCLES wait states.
// Request accepted only in IDLE; response held stable until rsp_ready, one outstanding at most.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, enter_resp;
  req_t        in_req, req_q, cur;
  logic [AW-1:0] idx;
  logic [63:0] rd_dword, load_data, merged;
  logic        misaligned, in_range, err;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0] mem [DEPTH];

  assign in_req = '{write: req_write, size: size_e'(req_size), is_unsigned: req_unsigned,
                    addr: req_addr, wdata: req_wdata};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign enter_resp = (state_q != ST_RESP) && (state_d == ST_RESP);

  // With zero wait states the access happens on the accepting edge, before req_q is loaded.
  assign cur      = (state_q == ST_IDLE) ? in_req : req_q;
  assign idx      = cur.addr[AW+2:3];
  assign in_range = cur.addr[63:3] < 61'(DEPTH);
  assign rd_dword = mem[idx];
  assign err      = misaligned || !in_range;

  mem_lane_align u_align (
    .size        (cur.size),
    .is_unsigned (cur.is_unsigned),
    .offset      (cur.addr[2:0]),
    .wdata       (cur.wdata),
    .rd_dword    (rd_dword),
    .misaligned  (misaligned),
    .load_data   (load_data),
    .merged      (merged)
  );

  // Storage deliberately sits outside the reset domain.
  always_ff @(posedge clk) begin
    if (enter_resp && cur.write && !err) mem[idx] <= merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) req_q <= in_req;
      if (enter_resp) begin
        err_q   <= err;
        rdata_q <= (err || cur.write) ? 64'd0 : load_data;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder against a byte-array reference model.
module tb_mem_responder;

  localparam int DEPTH = 32;
  localparam int WAIT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [DEPTH*8];

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Byte-granular memory model: error rules, little-endian assembly, arithmetic extension.
  function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                input logic [63:0] a, input logic [63:0] wd,
                                output logic [63:0] exp_rd, output logic exp_err);
    int nb = 1 << sz;
    logic [63:0] v = 64'd0;
    exp_rd  = 64'd0;
    exp_err = ((a % 64'(nb)) != 64'd0) || ((a >> 3) >= 64'(DEPTH));
    if (exp_err) return;
    if (w) begin
      for (int i = 0; i < nb; i++) model_mem[int'(a) + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) v = v | ({56'd0, model_mem[int'(a) + i]} << (8*i));
      if (!u && nb < 8 && v[8*nb-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*nb));
      exp_rd = v;
    end
  endfunction

  task automatic run_xact(input string tag, input logic w, input logic [1:0] sz, input logic u,
                          input logic [63:0] a, input logic [63:0] wd, input int hold,
                          output logic [63:0] obs_rd, output logic obs_err);
    logic [63:0] exp_rd;
    logic        exp_err;
    int          lat;
    int          tmo;
    model(w, sz, u, a, wd, exp_rd, exp_err);
    @(negedge clk);
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    tmo = 0;
    while (!req_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk({tag, " latency"}, 64'(lat), 64'(WAIT + 1));
    if (!rsp_valid) $fatal(1, "FAIL %s: no response within cycle budget", tag);
    obs_rd  = rsp_rdata;
    obs_err = rsp_err;
    chk({tag, " rdata"}, rsp_rdata, exp_rd);
    chk({tag, " err"}, 64'(rsp_err), 64'(exp_err));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, " hold rdata"}, rsp_rdata, exp_rd);
      chk({tag, " hold err"}, 64'(rsp_err), 64'(exp_err));
      chk({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, " post req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, " post rsp_valid"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] rd, a, wd;
    logic        er, w, u;
    logic [1:0]  sz;
    int          pick;

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_err", 64'(rsp_err), 64'd0);
    chk("reset rsp_rdata", rsp_rdata, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < DEPTH; i++)
      run_xact("fill", 1'b1, 2'd3, 1'b0, 64'(i * 8), {$urandom, $urandom}, 0, rd, er);

    run_xact("st_d", 1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, 0, rd, er);
    run_xact("ld_d", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, rd, er);
    chk("ld_d const", rd, 64'h1122334455667788);
    chk("ld_d err const", 64'(er), 64'd0);

    run_xact("st_b", 1'b1, 2'd0, 1'b0, 64'h13, 64'hAB, 0, rd, er);
    run_xact("ld_d2", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, rd, er);
    chk("ld_d2 const", rd, 64'h11223344AB667788);

    run_xact("ld_b_s", 1'b0, 2'd0, 1'b0, 64'h13, 64'd0, 0, rd, er);
    chk("ld_b_s const", rd, 64'hFFFFFFFFFFFFFFAB);
    run_xact("ld_b_u", 1'b0, 2'd0, 1'b1, 64'h13, 64'd0, 0, rd, er);
    chk("ld_b_u const", rd, 64'h00000000000000AB);

    run_xact("st_w_mis", 1'b1, 2'd2, 1'b0, 64'h12, 64'hDEADBEEF, 0, rd, er);
    chk("st_w_mis err const", 64'(er), 64'd1);
    run_xact("ld_after_mis", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, rd, er);
    chk("ld_after_mis const", rd, 64'h11223344AB667788);
    run_xact("ld_oor", 1'b0, 2'd3, 1'b0, 64'(DEPTH * 8), 64'd0, 0, rd, er);
    chk("ld_oor err const", 64'(er), 64'd1);
    chk("ld_oor rdata const", rd, 64'd0);

    run_xact("hold5", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 5, rd, er);

    // Reset while a store to 0x20 sits in its wait states.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h20; req_wdata = 64'hDEADBEEF_CAFEF00D; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_wait rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_wait rsp_rdata", rsp_rdata, 64'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait req_ready", 64'(req_ready), 64'd1);
    chk("rst_wait rsp_valid after", 64'(rsp_valid), 64'd0);
    run_xact("ld_after_rst", 1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 0, rd, er);

    for (int n = 0; n < 250; n++) begin
      sz   = 2'($urandom_range(0, 3));
      w    = 1'($urandom_range(0, 1));
      u    = 1'($urandom_range(0, 1));
      pick = int'($urandom_range(0, 9));
      if (pick == 0)      a = 64'(DEPTH * 8) + 64'($urandom_range(0, 255));
      else if (pick == 1) a = {$urandom, $urandom};
      else                a = 64'($urandom_range(0, DEPTH * 8 - 1));
      if (pick >= 2 && pick <= 8) a = a & ~((64'd1 << sz) - 64'd1);
      wd = {$urandom, $urandom};
      run_xact("rand", w, sz, u, a, wd, int'($urandom_range(0, 2)), rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
